// File: rtl/tmds_decoder_if.sv
// Symbol-in / decoded-out bundle of the TMDS channel decoder.
// master drives symbols and observes results; slave is the decoder itself.
interface tmds_decoder_if;
  logic [9:0] in_symbol;
  logic [7:0] out_data;
  logic [1:0] out_c;
  logic       out_blank;
  logic       out_locked;
  logic       out_bitslip;

  modport master (
    output in_symbol,
    input  out_data, out_c, out_blank, out_locked, out_bitslip
  );

  modport slave (
    input  in_symbol,
    output out_data, out_c, out_blank, out_locked, out_bitslip
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: two-stage symbol decode plus a word-alignment FSM
// that qualifies control periods and requests bitslips until lock is found.
module tmds_decoder #(
  parameter int C_min_run       = 12,
  parameter int C_lock_runs     = 4,
  parameter int C_search_window = 4096,
  parameter int C_slip_settle   = 16
) (
  input  logic           clk_pixel,
  input  logic           reset,
  tmds_decoder_if.slave  bus
);

  localparam int C_run_w  = $clog2(C_min_run + 1);
  localparam int C_win_w  = $clog2(C_search_window) + 1;
  localparam int C_good_w = $clog2(C_lock_runs) + 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [9:0]          sym_r;
  logic [C_run_w-1:0]  run_cnt_r;
  logic [C_win_w-1:0]  win_cnt_r;
  logic [C_win_w-1:0]  win_next_s;
  logic [C_good_w-1:0] good_cnt_r;
  logic                is_ctrl_s;
  logic [1:0]          ctrl_val_s;
  logic                qualified_s;
  logic                win_expire_s;
  logic                settle_done_s;
  logic [7:0]          out_data_r;
  logic [1:0]          out_c_r;
  logic                out_blank_r;
  logic                out_locked_r;
  logic                out_bitslip_r;

  function automatic logic [7:0] decode_data(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] q;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    q    = 8'h00;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

  // Input symbol capture stage
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      sym_r <= 10'h000;
    end else begin
      sym_r <= bus.in_symbol;
    end
  end

  // Control token classification
  always_comb begin
    is_ctrl_s  = 1'b1;
    ctrl_val_s = 2'b00;
    case (sym_r)
      10'h354: ctrl_val_s = 2'b00;
      10'h0AB: ctrl_val_s = 2'b01;
      10'h154: ctrl_val_s = 2'b10;
      10'h2AB: ctrl_val_s = 2'b11;
      default: begin
        is_ctrl_s  = 1'b0;
        ctrl_val_s = 2'b00;
      end
    endcase
  end

  // Decoded output stage; out_c only moves on control tokens
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      out_data_r  <= 8'h00;
      out_c_r     <= 2'b00;
      out_blank_r <= 1'b1;
    end else begin
      out_blank_r <= is_ctrl_s;
      if (is_ctrl_s) begin
        out_data_r <= 8'h00;
        out_c_r    <= ctrl_val_s;
      end else begin
        out_data_r <= decode_data(sym_r);
        out_c_r    <= out_c_r;
      end
    end
  end

  // Run qualification and window timing; the window counter also times SETTLE
  always_comb begin
    win_next_s    = win_cnt_r + C_win_w'(1);
    win_expire_s  = (win_next_s == C_win_w'(C_search_window));
    settle_done_s = (win_next_s == C_win_w'(C_slip_settle));
    qualified_s   = 1'b0;
    if (is_ctrl_s && (state_r != SETTLE) && (run_cnt_r == C_run_w'(C_min_run - 1))) begin
      qualified_s = 1'b1;
    end else begin
      qualified_s = 1'b0;
    end
  end

  // Alignment FSM next state; a qualified run takes priority over expiry
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SEARCH: begin
        if (qualified_s) begin
          if (good_cnt_r == C_good_w'(C_lock_runs - 1)) begin
            state_next_s = LOCKED;
          end else begin
            state_next_s = SEARCH;
          end
        end else if (win_expire_s) begin
          state_next_s = SLIP;
        end else begin
          state_next_s = SEARCH;
        end
      end
      SLIP:   state_next_s = SETTLE;
      SETTLE: begin
        if (settle_done_s) begin
          state_next_s = SEARCH;
        end else begin
          state_next_s = SETTLE;
        end
      end
      LOCKED: begin
        if (qualified_s) begin
          state_next_s = LOCKED;
        end else if (win_expire_s) begin
          state_next_s = SEARCH;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: state_next_s = SEARCH;
    endcase
  end

  // Run, window and good-run counters
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      run_cnt_r  <= '0;
      win_cnt_r  <= '0;
      good_cnt_r <= '0;
    end else begin
      if ((state_r == SETTLE) || !is_ctrl_s) begin
        run_cnt_r <= '0;
      end else if (run_cnt_r != C_run_w'(C_min_run)) begin
        run_cnt_r <= run_cnt_r + C_run_w'(1);
      end else begin
        run_cnt_r <= run_cnt_r;
      end

      if ((state_next_s != state_r) || qualified_s) begin
        win_cnt_r <= '0;
      end else begin
        win_cnt_r <= win_next_s;
      end

      if ((state_next_s != state_r) || (win_expire_s && !qualified_s)) begin
        good_cnt_r <= '0;
      end else if (qualified_s && (state_r == SEARCH)) begin
        good_cnt_r <= good_cnt_r + C_good_w'(1);
      end else begin
        good_cnt_r <= good_cnt_r;
      end
    end
  end

  // State register with status outputs that track the state exactly
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_r       <= SEARCH;
      out_locked_r  <= 1'b0;
      out_bitslip_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      out_locked_r  <= (state_next_s == LOCKED);
      out_bitslip_r <= (state_next_s == SLIP);
    end
  end

  assign bus.out_data    = out_data_r;
  assign bus.out_c       = out_c_r;
  assign bus.out_blank   = out_blank_r;
  assign bus.out_locked  = out_locked_r;
  assign bus.out_bitslip = out_bitslip_r;

endmodule
